// File: rtl/load_store_unit.sv
// load_store_unit: initiator of the data_memory port.
// RV32 loads/stores, read-modify-write for SB/SH.
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        memR,
    output logic        memW,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state;
    logic        store_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        f3_ok;
    logic        mis;
    logic        oor;
    logic        bad;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // strobes decode the registered state; reset masks them at once
    assign req_ready = (state == S_IDLE) && !rst;
    assign memR      = (state == S_READ) && !rst;
    assign memW      = (state == S_WRITE) && !rst;

    // request legality: funct3, alignment and address range
    always_comb begin
        f3_ok = 1'b0;
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_store;
            default:                f3_ok = 1'b0;
        endcase
        mis = (req_funct3[1:0] == 2'b01 && req_addr[0])
            || (req_funct3[1:0] == 2'b10
                && req_addr[1:0] != 2'b00);
        oor = |req_addr[31:ADDR_W+2];
        bad = !f3_ok || mis || oor;
    end

    // lane extraction and extension of the read word
    always_comb begin
        byte_sel = mem_rdata[7:0];
        unique case (lane_q)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16]
                             : mem_rdata[15:0];
        load_ext = mem_rdata;
        unique case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // sub-word store: replace the addressed lane of the old word
    always_comb begin
        merged = mem_rdata;
        if (f3_q[1:0] == 2'b00) begin
            unique case (lane_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (f3_q[1:0] == 2'b01) begin
            if (lane_q[1])
                merged[31:16] = wdata_q;
            else
                merged[15:0] = wdata_q;
        end
    end

    // access sequencer with registered response and memory bus
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            store_q    <= 1'b0;
            f3_q       <= 3'd0;
            lane_q     <= 2'd0;
            wdata_q    <= 16'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        store_q <= req_store;
                        f3_q    <= req_funct3;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata[15:0];
                        if (bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                            state      <= S_RESP;
                        end else begin
                            mem_addr <=
                                32'(req_addr[ADDR_W+1:2]);
                            if (req_store
                                && req_funct3 == 3'b010) begin
                                mem_wdata <= req_wdata;
                                state     <= S_WRITE;
                            end else begin
                                state <= S_READ;
                            end
                        end
                    end
                end
                S_READ: state <= S_MERGE;
                S_MERGE: begin
                    if (store_q) begin
                        mem_wdata <= merged;
                        state     <= S_WRITE;
                    end else begin
                        resp_rdata <= load_ext;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_WRITE: begin
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'd0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench with a response
// scoreboard and a word-indexed memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        memR;
    logic        memW;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];
    logic [255:0] written = '0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .memR       (memR),
        .memW       (memW),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // memory model: word i holds i until first written
    always @(posedge clk) begin
        if (memR) begin
            if (written[mem_addr[7:0]])
                mem_rdata <= mem[mem_addr[7:0]];
            else
                mem_rdata <= {24'd0, mem_addr[7:0]};
            rd_cnt <= rd_cnt + 1;
        end
        if (memW) begin
            mem[mem_addr[7:0]]     <= mem_wdata;
            written[mem_addr[7:0]] <= 1'b1;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag,
                          input bit st,
                          input logic [2:0] f3,
                          input logic [31:0] addr,
                          input logic [31:0] wd,
                          input logic [31:0] exp_d,
                          input bit exp_e,
                          input int lat,
                          input int nrd,
                          input int nwr,
                          input logic [31:0] exp_wa,
                          input logic [31:0] exp_wd,
                          input int hold);
        int rd0;
        int wr0;
        int n;
        exp_t e;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        sb_q.push_back('{rdata: exp_d, err: exp_e});
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                n = i;
                break;
            end
        end
        chk({tag, ".lat"}, 32'(n), 32'(lat));
        if (n != 0 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int h = 0; h < hold; h++) begin
                chk({tag, ".hv"}, 32'(resp_valid), 32'd1);
                chk({tag, ".hd"}, resp_rdata, e.rdata);
                chk({tag, ".hr"}, 32'(req_ready), 32'd0);
                @(negedge clk);
            end
            chk({tag, ".data"}, resp_rdata, e.rdata);
            chk({tag, ".err"}, 32'(resp_err), 32'(e.err));
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
            @(negedge clk);
            chk({tag, ".vdone"}, 32'(resp_valid), 32'd0);
            chk({tag, ".rdy2"}, 32'(req_ready), 32'd1);
        end else begin
            sb_q.delete();
        end
        chk({tag, ".nrd"}, 32'(rd_cnt - rd0), 32'(nrd));
        chk({tag, ".nwr"}, 32'(wr_cnt - wr0), 32'(nwr));
        if (nwr > 0) begin
            chk({tag, ".wa"}, last_wa, exp_wa);
            chk({tag, ".wd"}, last_wd, exp_wd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.rdy", 32'(req_ready), 32'd0);
        chk("rst.v", 32'(resp_valid), 32'd0);
        chk("rst.r", 32'(memR), 32'd0);
        chk("rst.w", 32'(memW), 32'd0);
        chk("rst.a", mem_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_req("sw", 1, 3'b010, 32'h14, 32'hDEADBEEF,
               32'h0, 0, 2, 0, 1, 32'd5, 32'hDEADBEEF, 0);
        do_req("lw", 0, 3'b010, 32'h14, 32'h0,
               32'hDEADBEEF, 0, 3, 1, 0, 0, 0, 0);
        do_req("lb", 0, 3'b000, 32'h17, 32'h0,
               32'hFFFFFFDE, 0, 3, 1, 0, 0, 0, 0);
        do_req("lbu", 0, 3'b100, 32'h17, 32'h0,
               32'h000000DE, 0, 3, 1, 0, 0, 0, 0);
        do_req("lh", 0, 3'b001, 32'h14, 32'h0,
               32'hFFFFBEEF, 0, 3, 1, 0, 0, 0, 0);
        do_req("lhu", 0, 3'b101, 32'h16, 32'h0,
               32'h0000DEAD, 0, 3, 1, 0, 0, 0, 0);
        do_req("sb", 1, 3'b000, 32'h15, 32'h12,
               32'h0, 0, 4, 1, 1, 32'd5, 32'hDEAD12EF, 0);
        do_req("lw2", 0, 3'b010, 32'h14, 32'h0,
               32'hDEAD12EF, 0, 3, 1, 0, 0, 0, 0);
        do_req("sh", 1, 3'b001, 32'h1A, 32'hAAAA5678,
               32'h0, 0, 4, 1, 1, 32'd6, 32'h56780006, 0);
        do_req("e_mis", 0, 3'b010, 32'h16, 32'h0,
               32'h0, 1, 1, 0, 0, 0, 0, 0);
        do_req("e_sh", 1, 3'b001, 32'h21, 32'h0,
               32'h0, 1, 1, 0, 0, 0, 0, 0);
        do_req("e_oor", 0, 3'b010, 32'h400, 32'h0,
               32'h0, 1, 1, 0, 0, 0, 0, 0);
        do_req("e_f3", 0, 3'b011, 32'h0, 32'h0,
               32'h0, 1, 1, 0, 0, 0, 0, 0);
        do_req("e_sbu", 1, 3'b100, 32'h0, 32'h0,
               32'h0, 1, 1, 0, 0, 0, 0, 0);
        do_req("bp", 0, 3'b010, 32'hC, 32'h0,
               32'h3, 0, 3, 1, 0, 0, 0, 5);

        // SH to word 7, reset pulsed in its WRITE cycle
        wr0 = wr_cnt;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h1C;
        req_wdata  = 32'h0000BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rw.memw1", 32'(memW), 32'd1);
        chk("rw.addr", mem_addr, 32'd7);
        rst = 1'b1;
        #1;
        chk("rw.memw0", 32'(memW), 32'd0);
        chk("rw.rdy0", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rw.nwr", 32'(wr_cnt - wr0), 32'd0);
        chk("rw.v", 32'(resp_valid), 32'd0);
        chk("rw.e", 32'(resp_err), 32'd0);
        chk("rw.d", resp_rdata, 32'd0);
        chk("rw.a", mem_addr, 32'd0);
        chk("rw.wd", mem_wdata, 32'd0);
        chk("rw.rdy", 32'(req_ready), 32'd1);
        do_req("lw7", 0, 3'b010, 32'h1C, 32'h0,
               32'h7, 0, 3, 1, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
